// File: rtl/adder4_result_accum_if.sv
`default_nettype none
// ============================================================================
//  Module   : adder4_result_accum_if
//  Brief    : Result-in / batch-total-out handshake bundle for the accumulator
//  Revision : 1.0  initial release
// ============================================================================
interface adder4_result_accum_if #(
  parameter int ACC_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_sum;
  logic             in_c4;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic             out_ovf;
  logic [3:0]       out_cnt;

  modport master (
    output in_valid, in_sum, in_c4, out_ready,
    input  in_ready, out_valid, out_acc, out_ovf, out_cnt
  );

  modport slave (
    input  in_valid, in_sum, in_c4, out_ready,
    output in_ready, out_valid, out_acc, out_ovf, out_cnt
  );
endinterface
`default_nettype wire

// File: rtl/adder4_result_accum.sv
`default_nettype none
// ============================================================================
//  Module   : adder4_result_accum
//  Brief    : Sums COUNT 5-bit adder results into a wrapping batch total
//  Revision : 1.0  initial release
// ============================================================================
module adder4_result_accum #(
  parameter int COUNT = 4,
  parameter int ACC_W = 8
) (
  input  wire logic            clk,
  input  wire logic            rst,
  input  wire logic            clr,
  adder4_result_accum_if.slave bus
);

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;
  localparam logic [3:0] CNT_LAST = 4'(COUNT - 1);

  logic [0:0]       state;
  logic [0:0]       state_nxt;
  logic [ACC_W-1:0] acc;
  logic             ovf;
  logic [3:0]       cnt;
  logic             accept;
  logic             last;
  logic             take;
  logic [ACC_W:0]   sum;

  assign accept = bus.in_valid && bus.in_ready;
  assign last   = (cnt == CNT_LAST);
  assign take   = (state == ST_HOLD) && bus.out_ready;
  // Extra top bit of the sum is the wrap indicator feeding the sticky flag.
  assign sum    = {1'b0, acc} + {{(ACC_W-4){1'b0}}, bus.in_c4, bus.in_sum};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = ST_ACCUM;
    end else begin
      case (state)
        ST_ACCUM: if (accept && last) state_nxt = ST_HOLD;
        ST_HOLD:  if (bus.out_ready)  state_nxt = ST_ACCUM;
        default:  state_nxt = ST_ACCUM;
      endcase
    end
  end

  always_comb begin
    bus.in_ready  = (state == ST_ACCUM) && !rst;
    bus.out_valid = (state == ST_HOLD) && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst || clr || take) begin
      acc <= '0;
      ovf <= 1'b0;
      cnt <= 4'd0;
    end else if (accept) begin
      acc <= sum[ACC_W-1:0];
      ovf <= ovf | sum[ACC_W];
      cnt <= cnt + 4'd1;
    end
  end

  assign bus.out_acc = acc;
  assign bus.out_ovf = ovf;
  assign bus.out_cnt = cnt;

endmodule
`default_nettype wire

// File: tb/tb_adder4_result_accum.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adder4_result_accum
//  Brief    : Directed checks of the batch accumulator in three configurations
//  Revision : 1.0  initial release
// ============================================================================
module tb_adder4_result_accum;

  logic clk = 1'b0;
  logic rst;
  logic clr8, clr6, clr3;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   deliv8 = 0;
  int   last8 = 0;

  always #5 clk = ~clk;

  adder4_result_accum_if #(.ACC_W(8)) b8 ();
  adder4_result_accum_if #(.ACC_W(6)) b6 ();
  adder4_result_accum_if #(.ACC_W(8)) b3 ();

  adder4_result_accum #(.COUNT(4), .ACC_W(8)) u8 (.clk(clk), .rst(rst), .clr(clr8), .bus(b8));
  adder4_result_accum #(.COUNT(4), .ACC_W(6)) u6 (.clk(clk), .rst(rst), .clr(clr6), .bus(b6));
  adder4_result_accum #(.COUNT(3), .ACC_W(8)) u3 (.clk(clk), .rst(rst), .clr(clr3), .bus(b3));

  always @(posedge clk) begin
    if (b8.out_valid && b8.out_ready) begin
      deliv8 <= deliv8 + 1;
      last8  <= int'(b8.out_acc);
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    tests_run++;
    if (got != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push8(input logic c, input logic [3:0] s);
    b8.in_valid = 1'b1; b8.in_c4 = c; b8.in_sum = s;
    tick();
  endtask

  task automatic idle8();
    b8.in_valid = 1'b0;
    tick();
  endtask

  task automatic push6(input logic c, input logic [3:0] s);
    b6.in_valid = 1'b1; b6.in_c4 = c; b6.in_sum = s;
    tick();
  endtask

  initial begin
    int d0;
    int exp_cnt [5] = '{1, 1, 2, 2, 3};
    rst = 1'b1; clr8 = 1'b0; clr6 = 1'b0; clr3 = 1'b0;
    b8.in_valid = 0; b8.in_sum = 0; b8.in_c4 = 0; b8.out_ready = 0;
    b6.in_valid = 0; b6.in_sum = 0; b6.in_c4 = 0; b6.out_ready = 0;
    b3.in_valid = 0; b3.in_sum = 0; b3.in_c4 = 0; b3.out_ready = 0;
    tick(); tick();

    check("rst_in_ready", b8.in_ready, 0);
    check("rst_out_valid", b8.out_valid, 0);
    check("rst_acc", b8.out_acc, 0);
    check("rst_ovf", b8.out_ovf, 0);
    check("rst_cnt", b8.out_cnt, 0);
    rst = 1'b0;
    #1;
    check("rst_release_ready", b8.in_ready, 1);

    // Basic batch: 3 + 31 + 0 + 18 = 52
    b8.out_ready = 1'b1;
    push8(1'b0, 4'd3);
    check("b1_acc1", b8.out_acc, 3);
    check("b1_cnt1", b8.out_cnt, 1);
    push8(1'b1, 4'd15);
    check("b1_acc2", b8.out_acc, 34);
    push8(1'b0, 4'd0);
    check("b1_cnt3", b8.out_cnt, 3);
    check("b1_valid3", b8.out_valid, 0);
    push8(1'b1, 4'd2);
    check("b1_valid", b8.out_valid, 1);
    check("b1_acc", b8.out_acc, 52);
    check("b1_ovf", b8.out_ovf, 0);
    check("b1_cnt", b8.out_cnt, 4);
    check("b1_ready_hold", b8.in_ready, 0);
    idle8();
    check("b1_after_valid", b8.out_valid, 0);
    check("b1_after_ready", b8.in_ready, 1);
    check("b1_after_cnt", b8.out_cnt, 0);
    check("b1_after_acc", b8.out_acc, 0);

    // Backpressure: total 20 held while inputs keep arriving
    b8.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push8(1'b0, 4'd5);
    check("bp_valid", b8.out_valid, 1);
    check("bp_acc", b8.out_acc, 20);
    d0 = deliv8;
    for (int i = 0; i < 5; i++) begin
      b8.in_valid = 1'b1; b8.in_c4 = i[0]; b8.in_sum = 4'(i + 7);
      tick();
      check("bp_ready", b8.in_ready, 0);
      check("bp_hold_acc", b8.out_acc, 20);
      check("bp_hold_cnt", b8.out_cnt, 4);
      check("bp_hold_ovf", b8.out_ovf, 0);
    end
    b8.in_valid = 1'b0; b8.out_ready = 1'b1;
    tick();
    check("bp_deliv_once", deliv8, d0 + 1);
    check("bp_deliv_val", last8, 20);
    check("bp_valid_low", b8.out_valid, 0);
    tick();
    check("bp_deliv_still", deliv8, d0 + 1);

    // clr mid-batch drops partial sum and the coincident input
    push8(1'b0, 4'd7);
    push8(1'b0, 4'd7);
    check("clr_pre_acc", b8.out_acc, 14);
    clr8 = 1'b1;
    push8(1'b0, 4'd7);
    check("clr_cnt", b8.out_cnt, 0);
    check("clr_acc", b8.out_acc, 0);
    clr8 = 1'b0;
    for (int i = 0; i < 4; i++) push8(1'b0, 4'd1);
    check("clr_final_valid", b8.out_valid, 1);
    check("clr_final_acc", b8.out_acc, 4);
    idle8();

    // Reset mid-batch
    push8(1'b0, 4'd9);
    push8(1'b0, 4'd9);
    check("rmid_pre_acc", b8.out_acc, 18);
    b8.in_valid = 1'b0; rst = 1'b1;
    tick();
    check("rmid_acc", b8.out_acc, 0);
    check("rmid_cnt", b8.out_cnt, 0);
    check("rmid_ready", b8.in_ready, 0);
    check("rmid_valid", b8.out_valid, 0);
    rst = 1'b0;
    tick();
    check("rmid_ready_after", b8.in_ready, 1);
    for (int i = 0; i < 4; i++) push8(1'b0, 4'd2);
    check("rmid_batch_acc", b8.out_acc, 8);
    check("rmid_batch_valid", b8.out_valid, 1);
    idle8();

    // Reset while holding a pending total of 124
    b8.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push8(1'b1, 4'd15);
    check("rhold_valid", b8.out_valid, 1);
    check("rhold_acc", b8.out_acc, 124);
    b8.in_valid = 1'b0; rst = 1'b1;
    tick();
    check("rhold_rst_valid", b8.out_valid, 0);
    check("rhold_rst_acc", b8.out_acc, 0);
    check("rhold_rst_ready", b8.in_ready, 0);
    check("rhold_rst_cnt", b8.out_cnt, 0);
    rst = 1'b0;
    tick();
    check("rhold_ready_after", b8.in_ready, 1);
    check("rhold_valid_after", b8.out_valid, 0);
    b8.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) push8(1'b0, 4'd1);
    check("rhold_next_acc", b8.out_acc, 4);
    check("rhold_next_ovf", b8.out_ovf, 0);
    idle8();

    // 6-bit accumulator wraps: 124 mod 64 = 60
    b6.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) push6(1'b1, 4'd15);
    check("w6_valid", b6.out_valid, 1);
    check("w6_acc", b6.out_acc, 60);
    check("w6_ovf", b6.out_ovf, 1);
    check("w6_cnt", b6.out_cnt, 4);
    b6.in_valid = 1'b0;
    tick();
    check("w6_clear_ovf", b6.out_ovf, 0);
    check("w6_clear_valid", b6.out_valid, 0);
    for (int i = 0; i < 4; i++) push6(1'b0, 4'd1);
    check("w6_next_acc", b6.out_acc, 4);
    check("w6_next_ovf", b6.out_ovf, 0);
    b6.in_valid = 1'b0;
    tick();

    // COUNT=3 with in_valid toggling: accepts data 1, 3, 5
    b3.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      b3.in_valid = (i % 2 == 0); b3.in_c4 = 1'b0; b3.in_sum = 4'(i + 1);
      tick();
      check("tog_cnt", b3.out_cnt, exp_cnt[i]);
      check("tog_valid", b3.out_valid, (i == 4) ? 1 : 0);
    end
    check("tog_acc", b3.out_acc, 9);
    b3.in_valid = 1'b0;
    tick();
    check("tog_done_ready", b3.in_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/adder4_result_accum.md
# adder4_result_accum

Downstream consumer of the 4-bit adder stage. Takes each adder result, {C4, S[3:0]} as an unsigned 5-bit value 0..31, over a valid/ready handshake. Sums COUNT consecutive results into a wrapping accumulator with a sticky overflow flag, then presents the batch total on a valid/ready output until it is taken. Sits between the adder stage and the output pins / downstream logic of the design.

## Interface
- COUNT, 4: results per batch; legal range 1..15.
- ACC_W, 8: accumulator width in bits; legal range 5..16.

- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- clr  input  1  synchronous batch abort; effective only while rst is low.
- in_valid  input  1  in_sum/in_c4 carry a result.
- in_ready  output  1  block accepts a result this cycle.
- in_sum  input  4  adder sum S[3:0].
- in_c4  input  1  adder carry-out C4.
- out_valid  output  1  batch total available.
- out_ready  input  1  downstream takes the total.
- out_acc  output  ACC_W  batch total, modulo 2^ACC_W.
- out_ovf  output  1  at least one wrap occurred in this batch.
- out_cnt  output  4  results accepted so far in the current batch.

## Operation
- Input value v = {in_c4, in_sum}, zero-extended to ACC_W+1 bits.
- A result is accepted on an edge where in_valid && in_ready.
- Two-state FSM:
  - ACCUM: in_ready = 1 and out_valid = 0.
  - HOLD: in_ready = 0 and out_valid = 1.
- In ACCUM, on an accept:
  - acc <= (acc + v) mod 2^ACC_W.
  - ovf <= ovf | carry-out of that addition.
  - cnt <= cnt + 1.
- In ACCUM, if the accept makes cnt reach COUNT: go to HOLD. cnt holds at COUNT.
- In HOLD, on out_valid && out_ready: acc <= 0, ovf <= 0, cnt <= 0, go to ACCUM.
- In HOLD, out_acc, out_ovf and out_cnt stay constant while out_ready is low.
- in_valid and the input data are ignored in HOLD.
- clr, from either state: acc, ovf and cnt cleared, state goes to ACCUM. Any pending total is discarded. A result presented on the same edge is dropped.
- Priority: rst > clr > output handshake > input accept.
- in_ready = (state == ACCUM) && !rst. It is combinational from registered state only; there is no dependence on in_valid.
- out_valid = (state == HOLD) && !rst.
- Reset values: state ACCUM, acc 0, ovf 0, cnt 0.
  - Outputs during and after reset: out_valid 0, out_acc 0, out_ovf 0, out_cnt 0.
  - in_ready is 0 while rst is high and 1 from the first cycle after rst falls.

## Timing
- Accept-to-update latency is 1 cycle: out_acc and out_cnt show the new value after the accepting edge.
- The COUNT-th accept asserts out_valid in the next cycle, with out_acc already including that result.
- There is no bypass.
  - The edge that completes the output handshake cannot also accept a new input.
  - in_ready returns 1 the cycle after that edge.
  - Minimum batch period is COUNT + 1 cycles.
- Back-to-back input is accepted every cycle in ACCUM.
- rst high mid-batch or in HOLD: all state is cleared at that edge, and the partial batch or pending total is lost.
- clr and out_ready both high on the same HOLD edge: clr wins. The result is identical (cleared, ACCUM), but the total counts as discarded, not delivered.

## Test plan
- COUNT=4, ACC_W=8. Feed (c4,s) = (0,3), (1,15), (0,0), (1,2) back-to-back with out_ready=1.
  - Required: out_valid=1 one cycle after the 4th accept, out_acc=0x34 (52), out_ovf=0, out_cnt=4.
  - Required: in_ready=1 again one cycle after the handshake.
- COUNT=4, ACC_W=6. Feed (1,15) four times.
  - Required: out_acc=60 (124 mod 64), out_ovf=1.
  - Required: next batch of four (0,1) gives out_acc=4, out_ovf=0.
- Backpressure: complete a batch, hold out_ready=0 for 5 cycles with in_valid=1 and changing data.
  - Required: in_ready=0, out_acc/out_ovf/out_cnt unchanged, no input accepted.
  - Required: out_ready=1 then delivers the original total exactly once.
- clr after 2 accepts of (0,7), then four accepts of (0,1).
  - Required: out_cnt=0 the cycle after clr.
  - Required: final out_acc=4.
- Reset in HOLD and reset mid-batch (rst high for 1 cycle).
  - Required: all outputs 0 and in_ready=0 during the rst cycle.
  - Required: in_ready=1 the following cycle, and the next batch total excludes pre-reset data.
- in_valid toggling every other cycle with COUNT=3, ACC_W=8.
  - Required: only cycles with in_valid && in_ready count.
  - Required: out_cnt increments exactly on those edges, and out_valid rises after the 3rd accept.
